// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, bubble encoding and redirect causes.
package core_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  // Reserved for tagging redirects once decode reports their origin.
  typedef enum logic [1:0] {
    RedirBranch = 2'd0,
    RedirJal    = 2'd1,
    RedirJalr   = 2'd2,
    RedirRsvd   = 2'd3
  } redirect_cause_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect and decode handshake.
interface fetch_unit_if
  import core_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 15
) ();

    logic                   mem_en;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic [INSTR_WIDTH-1:0] mem_data;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc;

    modport master (
        output mem_en, mem_addr, out_valid, out_instr, out_pc,
        input  mem_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_en, mem_addr, out_valid, out_instr, out_pc,
        output mem_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with push/pop/flush; flush wins over push.
module fetch_queue #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       head_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: Depth must be a power of two >= 2");
    end

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != (AddrW + 1)'(Depth)) || do_pop);
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AddrW{1'b0}}, do_push} - {{AddrW{1'b0}}, do_pop};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Credit-based pipelined instruction fetcher with prefetch queue and single-cycle redirect.
module fetch_unit
  import core_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 15,
    parameter int unsigned         MEM_LATENCY = 2,
    parameter int unsigned         QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned SumW = $clog2(QUEUE_DEPTH + MEM_LATENCY + 1) + 1;

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("fetch_unit: MEM_LATENCY must be >= 1");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_unit: QUEUE_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic                valid;
        logic                epoch;
        logic [PC_WIDTH-1:0] pc;
    } inflight_t;

    inflight_t           sr_q [MEM_LATENCY];
    inflight_t           sr_d [MEM_LATENCY];
    inflight_t           tail;
    logic [PC_WIDTH-1:0] fetch_pc_q, issue_pc;
    logic                epoch_q, epoch_d;
    logic                redirect, issue, credit_ok, push, pop, out_valid;
    logic [SumW-1:0]     inflight_cnt;
    logic [CntW-1:0]     q_count;
    logic [INSTR_WIDTH+PC_WIDTH-1:0] q_head;

    always_comb begin
        redirect     = !rst && bus.redirect_valid;
        inflight_cnt = '0;
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            if (sr_q[i].valid && (sr_q[i].epoch == epoch_q)) begin
                inflight_cnt = inflight_cnt + SumW'(1);
            end
        end
        // Credits use this cycle's counts; a same-cycle pop frees nothing yet.
        credit_ok = (inflight_cnt + SumW'(q_count)) < SumW'(QUEUE_DEPTH);
        issue     = !rst && (bus.redirect_valid || credit_ok);
        issue_pc  = redirect ? bus.redirect_pc : fetch_pc_q;
        epoch_d   = epoch_q ^ redirect;

        tail      = sr_q[MEM_LATENCY-1];
        push      = !redirect && tail.valid && (tail.epoch == epoch_q);
        out_valid = !rst && !bus.redirect_valid && (q_count != '0);
        pop       = out_valid && bus.out_ready;

        sr_d[0] = '{valid: issue, epoch: epoch_d, pc: issue_pc};
        for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            sr_d[i]       = sr_q[i-1];
            // Clearing valid on redirect keeps stale reads out even if the epoch bit aliases.
            sr_d[i].valid = sr_q[i-1].valid && !redirect;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            epoch_q <= epoch_d;
            if (issue) begin
                fetch_pc_q <= issue_pc + 1'b1;
            end
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    fetch_queue #(
        .Width (INSTR_WIDTH + PC_WIDTH),
        .Depth (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i ({bus.mem_data, tail.pc}),
        .pop_i       (pop),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    assign bus.mem_en                   = issue;
    assign bus.mem_addr                 = issue_pc;
    assign bus.out_valid                = out_valid;
    assign {bus.out_instr, bus.out_pc}  = q_head;

endmodule
